serial_add_ctrl: RTL and testbench

//   Bit-serial add/subtract sequencer built around one shared full_adder cell.

---
 rtl/serial_add_ctrl_pkg.sv | 22 ++
 rtl/full_adder.sv | 22 ++
 rtl/serial_add_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl_pkg
// Brief    : Shared state encoding and op-select constants for the bit-serial
//            add/subtract sequencer.
// Revision : 1.0  initial release
// ============================================================================
package serial_add_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Values of the sub input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : serial_add_ctrl_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Brief    : Single-bit full adder cell shared by the serial sequencer.
// Revision : 1.0  initial release
// ============================================================================
module full_adder (
    input  logic inbit_0,
    input  logic inbit_1,
    input  logic carry_in,
    output logic outbit_0,
    output logic carry_out
);

    // Sum and carry of three input bits
    always_comb begin
        outbit_0  = inbit_0 ^ inbit_1 ^ carry_in;
        carry_out = (inbit_0 & inbit_1) | (carry_in & (inbit_0 ^ inbit_1));
    end

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Brief    : Bit-serial add/subtract sequencer. Steps one full_adder cell
//            LSB-first for WIDTH cycles, recirculating the carry, and returns
//            result, carry and signed overflow with a one-cycle done pulse.
// Revision : 1.0  initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_sh_a;
    logic [WIDTH-1:0]   r_sh_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_carry_out;
    logic               r_overflow;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_accept;
    logic               w_last;
    logic               w_fa_sum;
    logic               w_fa_carry;

    assign w_accept  = ready & start;
    assign w_last    = (r_cnt == c_last_bit);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

    // The one shared adder cell, fed from the LSBs of the shift registers
    full_adder u_full_adder (
        .inbit_0   (r_sh_a[0]),
        .inbit_1   (r_sh_b[0]),
        .carry_in  (r_carry),
        .outbit_0  (w_fa_sum),
        .carry_out (w_fa_carry)
    );

    // State register; an async reset mid-RUN drops back to IDLE with no done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and status decode; DONE also accepts so ops can run back-to-back
    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                ready        = 1'b1;
                done         = 1'b1;
                w_next_state = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand load on accept, then one bit per RUN cycle; subtract is a + ~b + 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_cnt       <= '0;
        end else if (w_accept) begin
            r_sh_a      <= op_a;
            r_sh_b      <= (sub == OP_SUB) ? ~op_b : op_b;
            r_carry     <= (sub == OP_SUB);
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_cnt       <= '0;
        end else if (r_state == ST_RUN) begin
            r_result <= {w_fa_sum, r_result[WIDTH-1:1]};
            r_sh_a   <= r_sh_a >> 1;
            r_sh_b   <= r_sh_b >> 1;
            r_carry  <= w_fa_carry;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                // r_carry here is the carry into the MSB position
                r_carry_out <= w_fa_carry;
                r_overflow  <= r_carry ^ w_fa_carry;
            end
        end
    end

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Brief    : Directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op and wait (bounded) for done; lat = negedges after the
    // accept edge at which done is first seen, or -1 on timeout.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          output int lat, output logic [7:0] res,
                          output logic co, output logic ov);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        res = 'x;
        co  = 1'bx;
        ov  = 1'bx;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                res = result;
                co  = carry_out;
                ov  = overflow;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
        checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat; logic [7:0] res; logic co, ov;
        run_op(8'h3C, 8'h05, 1'b0, lat, res, co, ov);
        checks++; if (lat !== 9) begin failures++; $display("FAIL add_3c05_latency got=%0d exp=9", lat); end
        checks++; if (res !== 8'h41) begin failures++; $display("FAIL add_3c05_result got=%h exp=41", res); end
        checks++; if (co !== 1'b0 || ov !== 1'b0) begin failures++; $display("FAIL add_3c05_flags got co=%b ov=%b exp co=0 ov=0", co, ov); end
        run_op(8'hFF, 8'h01, 1'b0, lat, res, co, ov);
        checks++; if (lat !== 9 || res !== 8'h00) begin failures++; $display("FAIL add_ff01_result got=%h lat=%0d exp=00 lat=9", res, lat); end
        checks++; if (co !== 1'b1 || ov !== 1'b0) begin failures++; $display("FAIL add_ff01_flags got co=%b ov=%b exp co=1 ov=0", co, ov); end
        run_op(8'h7F, 8'h01, 1'b0, lat, res, co, ov);
        checks++; if (lat !== 9 || res !== 8'h80) begin failures++; $display("FAIL add_7f01_result got=%h lat=%0d exp=80 lat=9", res, lat); end
        checks++; if (co !== 1'b0 || ov !== 1'b1) begin failures++; $display("FAIL add_7f01_flags got co=%b ov=%b exp co=0 ov=1", co, ov); end
    endtask

    task automatic test_sub();
        int lat; logic [7:0] res; logic co, ov;
        run_op(8'h05, 8'h07, 1'b1, lat, res, co, ov);
        checks++; if (lat !== 9 || res !== 8'hFE) begin failures++; $display("FAIL sub_0507_result got=%h lat=%0d exp=fe lat=9", res, lat); end
        checks++; if (co !== 1'b0 || ov !== 1'b0) begin failures++; $display("FAIL sub_0507_flags got co=%b ov=%b exp co=0 ov=0", co, ov); end
        run_op(8'h80, 8'h01, 1'b1, lat, res, co, ov);
        checks++; if (lat !== 9 || res !== 8'h7F) begin failures++; $display("FAIL sub_8001_result got=%h lat=%0d exp=7f lat=9", res, lat); end
        checks++; if (co !== 1'b1 || ov !== 1'b1) begin failures++; $display("FAIL sub_8001_flags got co=%b ov=%b exp co=1 ov=1", co, ov); end
    endtask

    task automatic test_ignore_start();
        int n_done = 0;
        logic [7:0] first_res = 'x;
        @(negedge clk);
        op_a = 8'h3C; op_b = 8'h05; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL ignore_busy got busy=%b ready=%b exp busy=1 ready=0", busy, ready); end
        op_a = 8'hAA; op_b = 8'h11; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (n_done == 1) first_res = result;
            end
        end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
        checks++; if (first_res !== 8'h41) begin failures++; $display("FAIL ignore_result got=%h exp=41", first_res); end
    endtask

    task automatic test_back_to_back();
        int gap = -1;
        logic [7:0] res1 = 'x;
        logic co1 = 1'bx;
        logic seen1 = 1'b0;
        @(negedge clk);
        op_a = 8'hFF; op_b = 8'hFF; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin seen1 = 1'b1; res1 = result; co1 = carry_out; break; end
        end
        checks++; if (seen1 !== 1'b1 || res1 !== 8'hFE || co1 !== 1'b1) begin failures++; $display("FAIL b2b_first got done=%b res=%h co=%b exp done=1 res=fe co=1", seen1, res1, co1); end
        // Still in DONE with start high: this edge accepts the second op
        op_a = 8'h50; op_b = 8'h20; sub = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_accept got busy=%b done=%b exp busy=1 done=0", busy, done); end
        checks++; if (result !== 8'h00 || carry_out !== 1'b0) begin failures++; $display("FAIL b2b_clear got res=%h co=%b exp res=00 co=0", result, carry_out); end
        for (int i = 2; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin gap = i; break; end
        end
        checks++; if (gap !== 9) begin failures++; $display("FAIL b2b_gap got=%0d exp=9", gap); end
        checks++; if (result !== 8'h30 || carry_out !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL b2b_second got res=%h co=%b ov=%b exp res=30 co=1 ov=0", result, carry_out, overflow); end
    endtask

    task automatic test_async_reset();
        int n_done = 0;
        int lat; logic [7:0] res; logic co, ov;
        @(negedge clk);
        op_a = 8'hFF; op_b = 8'h00; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (result === 8'h00) begin failures++; $display("FAIL arst_partial got=%h exp=nonzero", result); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (result !== 8'h00 || carry_out !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL arst_outputs got res=%h co=%b ov=%b exp 00 0 0", result, carry_out, overflow); end
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL arst_status got ready=%b busy=%b done=%b exp 1 0 0", ready, busy, done); end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        checks++; if (n_done !== 0) begin failures++; $display("FAIL arst_no_done got=%0d exp=0", n_done); end
        run_op(8'h7F, 8'h01, 1'b0, lat, res, co, ov);
        checks++; if (lat !== 9 || res !== 8'h80 || co !== 1'b0 || ov !== 1'b1) begin failures++; $display("FAIL arst_next_op got lat=%0d res=%h co=%b ov=%b exp 9 80 0 1", lat, res, co, ov); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_add_ctrl
`default_nettype wire
